// File: rtl/merge_atom_accum_fifo_based.sv
// merge_atom_accum_fifo_based
//   2-input merge atom for the SpMV merge tree. Each input stream is buffered
//   in its own FIFO. The atom merges two ascending row-index streams into one
//   ascending stream. When ADD_EN is set, it folds equal-row heads into a
//   single word. An explicit end-of-stream (EOS) word closes each vector.
//
//   Word layout: row = [DW-1 -: ROW_W], val = [DW-ROW_W-1 -: VAL_W],
//                bit0 = valid (0 marks the EOS terminator).
//
// Ports
//   clk, rst_b          clock, synchronous active-low reset
//   global_en           0 blocks new words from entering the output register
//   restart             pulse: leave DONE, clear done and comb_cnt
//   f0_wr_en/din_f0     push into FIFO 0 (dropped when full)
//   f1_wr_en/din_f1     push into FIFO 1 (dropped when full)
//   f0_full/f1_full     FIFO full flags
//   dout/dout_valid     registered merged word, accepted on dout_ready
//   done                terminator accepted, stream complete
//   comb_cnt            saturating count of equal-row combines

// Simple synchronous FIFO, depth 2^ASIZE, first-word-fall-through head.
module merge_atom_accum_fifo_based_sfifo #(
    parameter int DW    = 32,
    parameter int ASIZE = 2
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          wr_en,
    input  logic [DW-1:0] din,
    input  logic          rd_en,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);
    localparam logic [ASIZE:0] PTR_ONE = 1;

    logic [DW-1:0]  mem [2**ASIZE];
    logic [ASIZE:0] wptr, rptr;
    logic           do_rd, do_wr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[ASIZE] != rptr[ASIZE]) &&
                   (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
    assign do_rd = rd_en & ~empty;
    // A full FIFO still takes a write when a pop frees a slot in the same cycle.
    assign do_wr = wr_en & (~full | do_rd);
    assign head  = mem[rptr[ASIZE-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + PTR_ONE;
            if (do_rd) rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[ASIZE-1:0]] <= din;
    end
endmodule

module merge_atom_accum_fifo_based #(
    parameter int ROW_W      = 8,
    parameter int VAL_W      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_ASIZE = 2,
    parameter int ADD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  global_en,
    input  logic                  restart,
    input  logic                  f0_wr_en,
    input  logic                  f1_wr_en,
    input  logic [DATA_WIDTH-1:0] din_f0,
    input  logic [DATA_WIDTH-1:0] din_f1,
    output logic                  f0_full,
    output logic                  f1_full,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  done,
    output logic [CNT_W-1:0]      comb_cnt
);
    localparam int VAL_HI = DATA_WIDTH - ROW_W - 1;
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [0:0] state;

    logic [1:0]                 wr_en, rd_en, full, empty;
    logic [1:0][DATA_WIDTH-1:0] din, head;

    assign wr_en   = {f1_wr_en, f0_wr_en};
    assign din     = {din_f1, din_f0};
    assign f0_full = full[0];
    assign f1_full = full[1];

    for (genvar i = 0; i < 2; i++) begin : g_fifo
        merge_atom_accum_fifo_based_sfifo #(
            .DW    (DATA_WIDTH),
            .ASIZE (FIFO_ASIZE)
        ) u_fifo (
            .clk   (clk),
            .rst_b (rst_b),
            .wr_en (wr_en[i]),
            .din   (din[i]),
            .rd_en (rd_en[i]),
            .head  (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    logic [ROW_W-1:0] h0_row, h1_row;
    logic [VAL_W-1:0] h0_val, h1_val, val_sum;
    logic             h0_v, h1_v;

    assign h0_row  = head[0][DATA_WIDTH-1 -: ROW_W];
    assign h1_row  = head[1][DATA_WIDTH-1 -: ROW_W];
    assign h0_val  = head[0][VAL_HI -: VAL_W];
    assign h1_val  = head[1][VAL_HI -: VAL_W];
    assign h0_v    = head[0][0];
    assign h1_v    = head[1][0];
    assign val_sum = h0_val + h1_val;

    // Head selection: which word to load and which FIFOs to pop.
    logic [DATA_WIDTH-1:0] sel_word;
    logic [1:0]            pop;
    logic                  comb;

    always_comb begin
        sel_word = head[0];
        pop      = 2'b01;
        comb     = 1'b0;
        if (!h0_v && !h1_v) begin
            pop = 2'b11;
        end else if (!h0_v) begin
            sel_word = head[1];
            pop      = 2'b10;
        end else if (!h1_v) begin
            pop = 2'b01;
        end else if ((ADD_EN != 0) && (h0_row == h1_row)) begin
            sel_word[VAL_HI -: VAL_W] = val_sum;
            pop  = 2'b11;
            comb = 1'b1;
        end else if (h1_row < h0_row) begin
            sel_word = head[1];
            pop      = 2'b10;
        end
    end

    logic eos_out, accept, fire;

    assign eos_out = dout_valid & ~dout[0];
    assign accept  = dout_valid & dout_ready;
    // An EOS sitting in dout blocks further fires. Words of the next vector
    // may already be queued, and they must not slip out ahead of done.
    assign fire    = (state == ST_RUN) & global_en & ~empty[0] & ~empty[1] &
                     (~dout_valid | dout_ready) & ~eos_out;
    assign rd_en   = fire ? pop : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state      <= ST_RUN;
            dout       <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            comb_cnt   <= '0;
        end else begin
            if (fire) begin
                dout       <= sel_word;
                dout_valid <= 1'b1;
                if (comb && (comb_cnt != {CNT_W{1'b1}}))
                    comb_cnt <= comb_cnt + CNT_ONE;
            end else if (accept) begin
                dout_valid <= 1'b0;
                if (eos_out) begin
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
            end
            if ((state == ST_DONE) && restart) begin
                state    <= ST_RUN;
                done     <= 1'b0;
                comb_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_merge_atom_accum_fifo_based.sv
module tb_merge_atom_accum_fifo_based;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_b, global_en, restart, f0_wr_en, f1_wr_en, dout_ready;
    logic [DW-1:0] din_f0, din_f1;
    logic          f0_full_a, f1_full_a, dv_a, done_a;
    logic          f0_full_b, f1_full_b, dv_b, done_b;
    logic [DW-1:0] dout_a, dout_b;
    logic [15:0]   cc_a, cc_b;

    always #5 clk = ~clk;

    merge_atom_accum_fifo_based #(.ROW_W(8), .VAL_W(16), .DATA_WIDTH(DW),
        .FIFO_ASIZE(2), .ADD_EN(1), .CNT_W(16)) u_add (
        .clk(clk), .rst_b(rst_b), .global_en(global_en), .restart(restart),
        .f0_wr_en(f0_wr_en), .f1_wr_en(f1_wr_en), .din_f0(din_f0), .din_f1(din_f1),
        .f0_full(f0_full_a), .f1_full(f1_full_a), .dout(dout_a), .dout_valid(dv_a),
        .dout_ready(dout_ready), .done(done_a), .comb_cnt(cc_a));

    merge_atom_accum_fifo_based #(.ROW_W(8), .VAL_W(16), .DATA_WIDTH(DW),
        .FIFO_ASIZE(2), .ADD_EN(0), .CNT_W(16)) u_mrg (
        .clk(clk), .rst_b(rst_b), .global_en(global_en), .restart(restart),
        .f0_wr_en(f0_wr_en), .f1_wr_en(f1_wr_en), .din_f0(din_f0), .din_f1(din_f1),
        .f0_full(f0_full_b), .f1_full(f1_full_b), .dout(dout_b), .dout_valid(dv_b),
        .dout_ready(dout_ready), .done(done_b), .comb_cnt(cc_b));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] w(input int row, input int val);
        logic [31:0] r;
        r        = '0;
        r[31:24] = row[7:0];
        r[23:8]  = val[15:0];
        r[0]     = 1'b1;
        return r;
    endfunction

    localparam logic [31:0] EOS = 32'h0;

    typedef struct {
        int n0, n1, na, nb, cca, stall, gen_off;
        logic [2:0][31:0] f0, f1;
        logic [5:0][31:0] ea, eb;
    } vec_t;

    // Accepted-word monitor plus the done-one-cycle-after-EOS check.
    logic [31:0] qa[$], qb[$];
    logic pend_a = 1'b0, pend_b = 1'b0;
    always @(negedge clk) begin
        if (pend_a) chk("done_after_eos_a", {31'b0, done_a}, 32'd1);
        if (pend_b) chk("done_after_eos_b", {31'b0, done_b}, 32'd1);
        pend_a = rst_b && dv_a && dout_ready && !dout_a[0];
        pend_b = rst_b && dv_b && dout_ready && !dout_b[0];
        if (rst_b && dv_a && dout_ready) qa.push_back(dout_a);
        if (rst_b && dv_b && dout_ready) qb.push_back(dout_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input vec_t v);
        int n;
        n = (v.n0 > v.n1) ? v.n0 : v.n1;
        if (v.stall > 0) dout_ready = 1'b0;
        if (v.gen_off != 0) global_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            f0_wr_en = (i < v.n0);
            f1_wr_en = (i < v.n1);
            din_f0   = (i < v.n0) ? v.f0[i] : '0;
            din_f1   = (i < v.n1) ? v.f1[i] : '0;
            tick();
        end
        f0_wr_en = 1'b0;
        f1_wr_en = 1'b0;
        if (v.gen_off != 0) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("gen_off_no_valid", {31'b0, dv_a | dv_b}, 32'd0);
            end
            global_en = 1'b1;
        end
        for (int i = 0; i < v.stall; i++) begin
            tick();
            chk("stall_valid", {31'b0, dv_a}, 32'd1);
            chk("stall_dout", dout_a, v.ea[0]);
        end
        dout_ready = 1'b1;
    endtask

    task automatic finish_vec(input string tag, input vec_t v);
        int k;
        k = 0;
        while (!(done_a && done_b) && k < 80) begin
            tick();
            k++;
        end
        chk({tag, "_done"}, {31'b0, done_a & done_b}, 32'd1);
        chk({tag, "_len_a"}, qa.size(), v.na);
        chk({tag, "_len_b"}, qb.size(), v.nb);
        for (int j = 0; j < v.na; j++)
            if (j < qa.size()) chk({tag, "_word_a"}, qa[j], v.ea[j]);
        for (int j = 0; j < v.nb; j++)
            if (j < qb.size()) chk({tag, "_word_b"}, qb[j], v.eb[j]);
        chk({tag, "_comb_a"}, {16'b0, cc_a}, v.cca);
        chk({tag, "_comb_b"}, {16'b0, cc_b}, 32'd0);
        qa.delete();
        qb.delete();
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_done", {30'b0, done_a, done_b}, 32'd0);
        chk("restart_comb", {16'b0, cc_a}, 32'd0);
    endtask

    vec_t tbl[5];
    vec_t v;

    initial begin
        rst_b = 1'b0; global_en = 1'b1; restart = 1'b0; f0_wr_en = 1'b0;
        f1_wr_en = 1'b0; din_f0 = '0; din_f1 = '0; dout_ready = 1'b1;

        foreach (tbl[i]) begin
            tbl[i].n0 = 0; tbl[i].n1 = 0; tbl[i].na = 0; tbl[i].nb = 0;
            tbl[i].cca = 0; tbl[i].stall = 0; tbl[i].gen_off = 0;
            tbl[i].f0 = '0; tbl[i].f1 = '0; tbl[i].ea = '0; tbl[i].eb = '0;
        end
        // plain interleave
        tbl[0].n0 = 3; tbl[0].f0[0] = w(1, 11); tbl[0].f0[1] = w(4, 44); tbl[0].f0[2] = EOS;
        tbl[0].n1 = 3; tbl[0].f1[0] = w(2, 22); tbl[0].f1[1] = w(3, 33); tbl[0].f1[2] = EOS;
        tbl[0].na = 5; tbl[0].ea[0] = w(1, 11); tbl[0].ea[1] = w(2, 22);
        tbl[0].ea[2] = w(3, 33); tbl[0].ea[3] = w(4, 44); tbl[0].ea[4] = EOS;
        tbl[0].nb = 5; tbl[0].eb = tbl[0].ea;
        // equal rows: combine vs tie-to-f0
        tbl[1].n0 = 2; tbl[1].f0[0] = w(5, 10); tbl[1].f0[1] = EOS;
        tbl[1].n1 = 2; tbl[1].f1[0] = w(5, 7);  tbl[1].f1[1] = EOS;
        tbl[1].na = 2; tbl[1].ea[0] = w(5, 17); tbl[1].ea[1] = EOS; tbl[1].cca = 1;
        tbl[1].nb = 3; tbl[1].eb[0] = w(5, 10); tbl[1].eb[1] = w(5, 7); tbl[1].eb[2] = EOS;
        // two combines, the second wrapping the value field
        tbl[2].n0 = 3; tbl[2].f0[0] = w(3, 1); tbl[2].f0[1] = w(7, 2); tbl[2].f0[2] = EOS;
        tbl[2].n1 = 3; tbl[2].f1[0] = w(3, 4); tbl[2].f1[1] = w(7, 16'hFFFF); tbl[2].f1[2] = EOS;
        tbl[2].na = 3; tbl[2].ea[0] = w(3, 5); tbl[2].ea[1] = w(7, 1); tbl[2].ea[2] = EOS;
        tbl[2].cca = 2;
        tbl[2].nb = 5; tbl[2].eb[0] = w(3, 1); tbl[2].eb[1] = w(3, 4); tbl[2].eb[2] = w(7, 2);
        tbl[2].eb[3] = w(7, 16'hFFFF); tbl[2].eb[4] = EOS;
        // empty stream 0, global_en held low while loading
        tbl[3].n0 = 1; tbl[3].f0[0] = EOS;
        tbl[3].n1 = 3; tbl[3].f1[0] = w(2, 9); tbl[3].f1[1] = w(6, 1); tbl[3].f1[2] = EOS;
        tbl[3].na = 3; tbl[3].ea[0] = w(2, 9); tbl[3].ea[1] = w(6, 1); tbl[3].ea[2] = EOS;
        tbl[3].nb = 3; tbl[3].eb = tbl[3].ea; tbl[3].gen_off = 1;
        // extreme rows, 5-cycle output stall after the first word
        tbl[4].n0 = 2; tbl[4].f0[0] = w(255, 1); tbl[4].f0[1] = EOS;
        tbl[4].n1 = 3; tbl[4].f1[0] = w(0, 2); tbl[4].f1[1] = w(0, 3); tbl[4].f1[2] = EOS;
        tbl[4].na = 4; tbl[4].ea[0] = w(0, 2); tbl[4].ea[1] = w(0, 3);
        tbl[4].ea[2] = w(255, 1); tbl[4].ea[3] = EOS;
        tbl[4].nb = 4; tbl[4].eb = tbl[4].ea; tbl[4].stall = 5;

        tick(); tick();
        rst_b = 1'b1;
        tick();
        chk("rst_dout", dout_a, 32'h0);
        chk("rst_valid", {30'b0, dv_a, dv_b}, 32'd0);
        chk("rst_done", {30'b0, done_a, done_b}, 32'd0);
        chk("rst_comb", {16'b0, cc_a}, 32'd0);
        chk("rst_full", {30'b0, f0_full_a, f1_full_a}, 32'd0);

        foreach (tbl[i]) begin
            push_vec(tbl[i]);
            finish_vec($sformatf("vec%0d", i), tbl[i]);
            do_restart();
        end

        // Next vector queued while in DONE, then restart.
        push_vec(tbl[0]);
        finish_vec("pre_done", tbl[0]);
        push_vec(tbl[1]);
        tick(); tick();
        chk("done_hold", {30'b0, done_a, done_b}, 32'd3);
        chk("done_no_out", {30'b0, dv_a, dv_b}, 32'd0);
        do_restart();
        finish_vec("queued", tbl[1]);
        do_restart();

        // Fill FIFO 0 with FIFO 1 empty; an extra write must be dropped.
        for (int i = 1; i <= 4; i++) begin
            f0_wr_en = 1'b1; din_f0 = w(i, i * 3);
            tick();
        end
        din_f0 = w(9, 9);
        tick();
        f0_wr_en = 1'b0;
        chk("full_f0", {31'b0, f0_full_a}, 32'd1);
        chk("full_no_valid", {31'b0, dv_a}, 32'd0);
        f1_wr_en = 1'b1; din_f1 = EOS;
        tick();
        f1_wr_en = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        f0_wr_en = 1'b1; din_f0 = EOS;
        tick();
        f0_wr_en = 1'b0;
        v = tbl[0];
        v.na = 5; v.ea[0] = w(1, 3); v.ea[1] = w(2, 6); v.ea[2] = w(3, 9);
        v.ea[3] = w(4, 12); v.ea[4] = EOS;
        v.nb = 5; v.eb = v.ea; v.cca = 0;
        finish_vec("full", v);
        do_restart();

        // Reset mid-stream clears FIFOs and the output register.
        dout_ready = 1'b0;
        f0_wr_en = 1'b1; din_f0 = w(7, 7);
        f1_wr_en = 1'b1; din_f1 = w(8, 8);
        tick();
        f0_wr_en = 1'b0; f1_wr_en = 1'b0;
        tick();
        chk("pre_rst_valid", {31'b0, dv_a}, 32'd1);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        dout_ready = 1'b1;
        chk("mid_rst_valid", {30'b0, dv_a, dv_b}, 32'd0);
        chk("mid_rst_dout", dout_a, 32'h0);
        push_vec(tbl[0]);
        finish_vec("post_rst", tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
